ofifo_col_drain: RTL

- Output FIFO between the MAC array bottom row and the per-column SFP accumulators.
- Each column writes its psum independently; columns finish at skewed times.
- Rows are read out only when every column holds at least one entry, so all columns realign.
- Each accepted read produces one registered row plus a one-cycle out_valid strobe, which drives each SFP's acc input directly.

---
 rtl/ofifo_col_drain_pkg.sv | 15 +
 rtl/ofifo_col_drain_if.sv | 27 ++
 rtl/ofifo_col_drain_lane.sv | 54 +++++
 rtl/ofifo_col_drain.sv | 74 +++++++
 4 files changed

// File: rtl/ofifo_col_drain_pkg.sv
// Shared constants and helpers for the output FIFO and the SFP column bank.
//   COL, PSUM_BW, OFIFO_DEPTH : default array geometry
//   lane_lsb()                : LSB of lane 'lane' inside a flattened psum bus
package ofifo_col_drain_pkg;

  localparam int unsigned COL         = 8;
  localparam int unsigned PSUM_BW     = 16;
  localparam int unsigned OFIFO_DEPTH = 64;

  // Lane i of a flattened bus occupies [bw*(i+1)-1 : bw*i].
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/ofifo_col_drain_if.sv
// Handshake/data bundle between the MAC bottom row, the output FIFO and the SFPs.
//   master : producer/consumer side (drives wr, in, rd)
//   slave  : FIFO side (drives out, out_valid and status flags)
interface ofifo_col_drain_if #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16
);
  logic [col-1:0]         wr;
  logic [col*psum_bw-1:0] in;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   out_valid;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   overflow;

  modport master (
    output wr, in, rd,
    input  out, out_valid, o_valid, o_ready, o_full, overflow
  );

  modport slave (
    input  wr, in, rd,
    output out, out_valid, o_valid, o_ready, o_full, overflow
  );
endinterface

// File: rtl/ofifo_col_drain_lane.sv
// ofifo_lane: single-column circular FIFO with fall-through head.
//   clk, reset : clock, synchronous active-high reset (pointers only)
//   push, din  : write request and data; ignored when full unless popping
//   pop        : remove head; ignored when empty
//   dout       : current head entry (valid when !empty)
//   empty/full : combinational status from the pointers
module ofifo_lane #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(depth);

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [width-1:0] r_mem [depth];

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a full lane may still accept.
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ofifo_col_drain.sv
// ofifo_col_drain: per-column output FIFO that realigns skewed columns.
//   clk, reset : clock, synchronous active-high reset
//   bus.wr/in  : per-column write strobes and flattened psum lanes
//   bus.rd     : row read request, accepted only when every lane is non-empty
//   bus.out    : registered row, updated on each accepted read
//   bus.out_valid : one-cycle strobe following each accepted read
//   bus.o_valid / o_ready / o_full : all non-empty / all not-full / any full
//   bus.overflow  : sticky, set when a write hits a full lane
module ofifo_col_drain
  import ofifo_col_drain_pkg::*;
#(
  parameter int unsigned col     = COL,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned depth   = OFIFO_DEPTH
) (
  input logic              clk,
  input logic              reset,
  ofifo_col_drain_if.slave bus
);

  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_full;
  logic [col*psum_bw-1:0] w_row;
  logic                   w_all_valid;
  logic                   w_accept;
  logic                   w_ovf_hit;

  logic [col*psum_bw-1:0] r_out;
  logic                   r_out_valid;
  logic                   r_overflow;

  for (genvar g = 0; g < int'(col); g++) begin : g_lane
    localparam int unsigned LSB = lane_lsb(g, psum_bw);

    ofifo_lane #(
      .width (psum_bw),
      .depth (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .push  (bus.wr[g]),
      .din   (bus.in[LSB +: psum_bw]),
      .pop   (w_accept),
      .dout  (w_row[LSB +: psum_bw]),
      .empty (w_empty[g]),
      .full  (w_full[g])
    );
  end

  assign w_all_valid = ~|w_empty;
  assign w_accept    = bus.rd && w_all_valid;
  // A write to a full lane is only dropped when no read frees a slot that edge.
  assign w_ovf_hit   = |(bus.wr & w_full & {col{~w_accept}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept)  r_out      <= w_row;
      if (w_ovf_hit) r_overflow <= 1'b1;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.o_valid   = w_all_valid;
  assign bus.o_ready   = ~|w_full;
  assign bus.o_full    = |w_full;
  assign bus.overflow  = r_overflow;

endmodule
